// File: rtl/iir_out_checker.sv
// iir_out_checker: receiver-side checker that compares the IIR filter output stream against a loaded golden table.
// Optional macro IIR_CHK_TOL_EN: a sample only mismatches when it differs from golden by more than 1 LSB.
module iir_out_checker #(
    parameter int DEPTH   = 256,
    parameter int NB      = 8,
    parameter int TIMEOUT = 1024,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST_n,
    input  logic          LD_VALID,
    input  logic [NB-1:0] LD_DATA,
    input  logic          START,
    input  logic          CLR,
    input  logic          VIN,
    input  logic [NB-1:0] DIN,
    output logic          LD_FULL,
    output logic [AW:0]   SMP_CNT,
    output logic [AW:0]   ERR_CNT,
    output logic [AW-1:0] FIRST_ERR_IDX,
    output logic [NB-1:0] FIRST_ERR_GOT,
    output logic          DONE,
    output logic          PASS,
    output logic          TIMED_OUT,
    output logic          OVERRUN
);

    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [AW:0]   CNT_ZERO = {(AW + 1){1'b0}};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [WW-1:0] WD_ZERO  = {WW{1'b0}};
    localparam logic [WW-1:0] WD_ONE   = {{(WW - 1){1'b0}}, 1'b1};
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

    function automatic logic sample_bad(input logic [NB-1:0] got, input logic [NB-1:0] gold);
`ifdef IIR_CHK_TOL_EN
        logic signed [NB:0] diff;
        // One extra bit keeps -128 vs 127 from overflowing
        diff = $signed({got[NB-1], got}) - $signed({gold[NB-1], gold});
        sample_bad = (diff > $signed({{(NB - 1){1'b0}}, 2'b01})) ||
                     (diff < $signed({(NB + 1){1'b1}}));
`else
        sample_bad = (got != gold);
`endif
    endfunction

    logic [NB-1:0] mem_r [DEPTH];
    logic [1:0]    state_r, state_nxt_s;
    logic [AW:0]   n_loaded_r, n_loaded_nxt_s;
    logic [AW:0]   smp_cnt_r, smp_cnt_nxt_s;
    logic [AW:0]   err_cnt_r, err_cnt_nxt_s;
    logic [AW-1:0] fe_idx_r, fe_idx_nxt_s;
    logic [NB-1:0] fe_got_r, fe_got_nxt_s;
    logic          done_r, done_nxt_s;
    logic          pass_r, pass_nxt_s;
    logic          timed_out_r, timed_out_nxt_s;
    logic          overrun_r, overrun_nxt_s;
    logic          ld_full_r;
    logic [WW-1:0] wd_r, wd_nxt_s;
    logic          wr_en_s;
    logic [NB-1:0] golden_s;
    logic          mismatch_s;
    logic          first_s;

    assign golden_s   = mem_r[smp_cnt_r[AW-1:0]];
    assign mismatch_s = sample_bad(DIN, golden_s);
    assign first_s    = mismatch_s && (err_cnt_r == CNT_ZERO);

    // Next-state logic: CLR wins, then load/run/done handling
    always_comb begin
        state_nxt_s     = state_r;
        n_loaded_nxt_s  = n_loaded_r;
        smp_cnt_nxt_s   = smp_cnt_r;
        err_cnt_nxt_s   = err_cnt_r;
        fe_idx_nxt_s    = fe_idx_r;
        fe_got_nxt_s    = fe_got_r;
        done_nxt_s      = done_r;
        pass_nxt_s      = pass_r;
        timed_out_nxt_s = timed_out_r;
        overrun_nxt_s   = overrun_r;
        wd_nxt_s        = wd_r;
        wr_en_s         = 1'b0;
        if (CLR) begin
            state_nxt_s     = ST_IDLE;
            n_loaded_nxt_s  = CNT_ZERO;
            smp_cnt_nxt_s   = CNT_ZERO;
            err_cnt_nxt_s   = CNT_ZERO;
            fe_idx_nxt_s    = {AW{1'b0}};
            fe_got_nxt_s    = {NB{1'b0}};
            done_nxt_s      = 1'b0;
            pass_nxt_s      = 1'b0;
            timed_out_nxt_s = 1'b0;
            overrun_nxt_s   = 1'b0;
            wd_nxt_s        = WD_ZERO;
        end else begin
            case (state_r)
                ST_IDLE, ST_LOAD: begin
                    // n_loaded MSB set means the table is full
                    wr_en_s = LD_VALID && !n_loaded_r[AW];
                    n_loaded_nxt_s = wr_en_s ? (n_loaded_r + CNT_ONE) : n_loaded_r;
                    if (START) begin
                        state_nxt_s = ST_RUN;
                        wd_nxt_s    = WD_ZERO;
                    end else if (wr_en_s) begin
                        state_nxt_s = ST_LOAD;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_RUN: begin
                    if (n_loaded_r == CNT_ZERO) begin
                        state_nxt_s = ST_DONE;
                        done_nxt_s  = 1'b1;
                        pass_nxt_s  = 1'b0;
                    end else if (VIN) begin
                        wd_nxt_s      = WD_ZERO;
                        smp_cnt_nxt_s = smp_cnt_r + CNT_ONE;
                        err_cnt_nxt_s = mismatch_s ? (err_cnt_r + CNT_ONE) : err_cnt_r;
                        fe_idx_nxt_s  = first_s ? smp_cnt_r[AW-1:0] : fe_idx_r;
                        fe_got_nxt_s  = first_s ? DIN : fe_got_r;
                        if (smp_cnt_nxt_s == n_loaded_r) begin
                            state_nxt_s = ST_DONE;
                            done_nxt_s  = 1'b1;
                            pass_nxt_s  = (err_cnt_nxt_s == CNT_ZERO);
                        end else begin
                            state_nxt_s = ST_RUN;
                        end
                    end else if (wd_r == WD_LAST) begin
                        state_nxt_s     = ST_DONE;
                        done_nxt_s      = 1'b1;
                        pass_nxt_s      = 1'b0;
                        timed_out_nxt_s = 1'b1;
                    end else begin
                        wd_nxt_s = wd_r + WD_ONE;
                    end
                end
                ST_DONE: begin
                    overrun_nxt_s = overrun_r | VIN;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State and status registers
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_r     <= ST_IDLE;
            n_loaded_r  <= CNT_ZERO;
            smp_cnt_r   <= CNT_ZERO;
            err_cnt_r   <= CNT_ZERO;
            fe_idx_r    <= {AW{1'b0}};
            fe_got_r    <= {NB{1'b0}};
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            timed_out_r <= 1'b0;
            overrun_r   <= 1'b0;
            ld_full_r   <= 1'b0;
            wd_r        <= WD_ZERO;
        end else begin
            state_r     <= state_nxt_s;
            n_loaded_r  <= n_loaded_nxt_s;
            smp_cnt_r   <= smp_cnt_nxt_s;
            err_cnt_r   <= err_cnt_nxt_s;
            fe_idx_r    <= fe_idx_nxt_s;
            fe_got_r    <= fe_got_nxt_s;
            done_r      <= done_nxt_s;
            pass_r      <= pass_nxt_s;
            timed_out_r <= timed_out_nxt_s;
            overrun_r   <= overrun_nxt_s;
            ld_full_r   <= n_loaded_nxt_s[AW];
            wd_r        <= wd_nxt_s;
        end
    end

    // Golden table storage; contents are don't-care after reset
    always_ff @(posedge CLK) begin
        if (wr_en_s) begin
            mem_r[n_loaded_r[AW-1:0]] <= LD_DATA;
        end
    end

    assign LD_FULL       = ld_full_r;
    assign SMP_CNT       = smp_cnt_r;
    assign ERR_CNT       = err_cnt_r;
    assign FIRST_ERR_IDX = fe_idx_r;
    assign FIRST_ERR_GOT = fe_got_r;
    assign DONE          = done_r;
    assign PASS          = pass_r;
    assign TIMED_OUT     = timed_out_r;
    assign OVERRUN       = overrun_r;

endmodule

// File: tb/tb_iir_out_checker.sv
// Scoreboard bench for iir_out_checker: a queue-based reference model pushes expected status,
// a monitor pops and compares after every edge carrying VIN or a probe strobe.
module tb_iir_out_checker;
    localparam int DEPTH   = 8;
    localparam int NB      = 8;
    localparam int TIMEOUT = 16;
    localparam int AW      = 3;
    localparam int PH_LOAD = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_DONE = 2;

    logic          CLK = 1'b0;
    logic          RST_n = 1'b0;
    logic          LD_VALID = 1'b0;
    logic [NB-1:0] LD_DATA = 8'd0;
    logic          START = 1'b0;
    logic          CLR = 1'b0;
    logic          VIN = 1'b0;
    logic [NB-1:0] DIN = 8'd0;
    logic          LD_FULL;
    logic [AW:0]   SMP_CNT;
    logic [AW:0]   ERR_CNT;
    logic [AW-1:0] FIRST_ERR_IDX;
    logic [NB-1:0] FIRST_ERR_GOT;
    logic          DONE;
    logic          PASS;
    logic          TIMED_OUT;
    logic          OVERRUN;
    logic          probe = 1'b0;

    iir_out_checker #(.DEPTH(DEPTH), .NB(NB), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST_n(RST_n), .LD_VALID(LD_VALID), .LD_DATA(LD_DATA),
        .START(START), .CLR(CLR), .VIN(VIN), .DIN(DIN),
        .LD_FULL(LD_FULL), .SMP_CNT(SMP_CNT), .ERR_CNT(ERR_CNT),
        .FIRST_ERR_IDX(FIRST_ERR_IDX), .FIRST_ERR_GOT(FIRST_ERR_GOT),
        .DONE(DONE), .PASS(PASS), .TIMED_OUT(TIMED_OUT), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int smp; int err; int fidx; int fgot;
        int done; int pass; int tmo; int ovr; int full;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] gold[$];
    int m_ph, m_idle, m_smp, m_err, m_fidx, m_fgot, m_done, m_pass, m_tmo, m_ovr;
    int n_compared = 0;
    int n_mismatched = 0;

    task automatic chk(input string nm, input int got, input int want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, want, $time);
        end
    endtask

    function automatic bit is_bad(input logic [7:0] d, input logic [7:0] g);
        int diff;
        diff = int'($signed(d)) - int'($signed(g));
`ifdef IIR_CHK_TOL_EN
        return (diff > 1) || (diff < -1);
`else
        return diff != 0;
`endif
    endfunction

    task automatic model_clear();
        gold.delete();
        m_ph = PH_LOAD; m_idle = 0; m_smp = 0; m_err = 0; m_fidx = 0; m_fgot = 0;
        m_done = 0; m_pass = 0; m_tmo = 0; m_ovr = 0;
    endtask

    task automatic finish_run(input int p);
        m_ph = PH_DONE; m_done = 1; m_pass = p;
    endtask

    // One clock of stimulus; the model advances to the state expected after the coming edge
    task automatic step(input bit vin, input logic [7:0] d, input bit ld, input logic [7:0] ldd,
                        input bit st, input bit clr, input bit prb);
        @(negedge CLK);
        VIN = vin; DIN = d; LD_VALID = ld; LD_DATA = ldd; START = st; CLR = clr; probe = prb;
        if (clr) begin
            model_clear();
        end else if (m_ph == PH_LOAD) begin
            if (ld && gold.size() < DEPTH) gold.push_back(ldd);
            if (st) begin m_ph = PH_RUN; m_idle = 0; end
        end else if (m_ph == PH_RUN) begin
            if (gold.size() == 0) begin
                finish_run(0);
            end else if (vin) begin
                m_idle = 0;
                if (is_bad(d, gold[m_smp])) begin
                    if (m_err == 0) begin m_fidx = m_smp; m_fgot = int'(d); end
                    m_err++;
                end
                m_smp++;
                if (m_smp == gold.size()) finish_run((m_err == 0) ? 1 : 0);
            end else begin
                m_idle++;
                if (m_idle == TIMEOUT) begin m_tmo = 1; finish_run(0); end
            end
        end else begin
            if (vin) m_ovr = 1;
        end
        if (vin || prb)
            exp_q.push_back('{m_smp, m_err, m_fidx, m_fgot, m_done, m_pass, m_tmo, m_ovr,
                              (gold.size() == DEPTH) ? 1 : 0});
    endtask

    task automatic ld(input logic [7:0] v, input bit prb);  step(1'b0, 8'd0, 1'b1, v, 1'b0, 1'b0, prb); endtask
    task automatic st();                                     step(1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1); endtask
    task automatic snd(input logic [7:0] v);                 step(1'b1, v, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0); endtask
    task automatic idl(input bit prb);                       step(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, prb); endtask
    task automatic clr_step();                               step(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1); endtask

    // Monitor: compare DUT status just after any edge that carried VIN or a probe
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            if (VIN || probe) begin
                #1;
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("SMP_CNT", int'(SMP_CNT), e.smp);
                    chk("ERR_CNT", int'(ERR_CNT), e.err);
                    chk("FIRST_ERR_IDX", int'(FIRST_ERR_IDX), e.fidx);
                    chk("FIRST_ERR_GOT", int'(FIRST_ERR_GOT), e.fgot);
                    chk("DONE", int'(DONE), e.done);
                    chk("PASS", int'(PASS), e.pass);
                    chk("TIMED_OUT", int'(TIMED_OUT), e.tmo);
                    chk("OVERRUN", int'(OVERRUN), e.ovr);
                    chk("LD_FULL", int'(LD_FULL), e.full);
                end
            end
        end
    end

    logic [7:0] v;
    int n, gap, r;
    logic [7:0] base [4];

    initial begin
        base[0] = 8'd5; base[1] = 8'hFD; base[2] = 8'd127; base[3] = 8'h80;
        model_clear();
        repeat (2) @(negedge CLK);
        RST_n = 1'b1;
        idl(1'b1);

        // Exact match of {5,-3,127,-128}
        for (int i = 0; i < 4; i++) ld(base[i], 1'b0);
        st();
        for (int i = 0; i < 4; i++) snd(base[i]);
        idl(1'b1);
        clr_step();

        // Third sample off by one
        for (int i = 0; i < 4; i++) ld(base[i], 1'b0);
        st();
        for (int i = 0; i < 4; i++) snd((i == 2) ? 8'd126 : base[i]);
        clr_step();

        // -128 golden vs 127 fails in both builds
        ld(8'h80, 1'b0);
        st();
        snd(8'd127);
        clr_step();

        // Watchdog: one sample then silence
        for (int i = 0; i < 3; i++) ld(8'($urandom), 1'b0);
        st();
        snd(gold[0]);
        for (int i = 0; i < TIMEOUT + 2; i++) idl(1'b1);
        clr_step();

        // Overfill the table, then check a full run
        for (int i = 0; i < DEPTH + 2; i++) ld(8'($urandom), i >= DEPTH - 1);
        st();
        for (int i = 0; i < DEPTH; i++) snd((i == 5) ? 8'($urandom) : gold[i]);
        snd(8'h33);
        idl(1'b1);
        clr_step();

        // START with nothing loaded
        st();
        idl(1'b1);
        snd(8'h01);
        clr_step();

        // Randomized runs, odd iterations issue the last load together with START
        for (int it = 0; it < 8; it++) begin
            clr_step();
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n - 1; i++) ld(8'($urandom), 1'b0);
            if (it % 2 == 1) step(1'b0, 8'd0, 1'b1, 8'($urandom), 1'b1, 1'b0, 1'b1);
            else begin ld(8'($urandom), 1'b1); st(); end
            for (int i = 0; i < n; i++) begin
                gap = $urandom_range(0, 3);
                for (int j = 0; j < gap; j++) idl(1'b1);
                r = $urandom_range(0, 3);
                v = gold[i];
                if (r == 1) v = gold[i] + 8'd1;
                else if (r == 2) v = 8'($urandom);
                snd(v);
            end
            idl(1'b1);
            if (it % 3 == 0) snd(8'($urandom));
        end

        // Asynchronous reset between edges in the middle of a run
        clr_step();
        for (int i = 0; i < 3; i++) ld(8'($urandom), 1'b0);
        st();
        snd(gold[0]);
        @(negedge CLK);
        VIN = 1'b0; LD_VALID = 1'b0; START = 1'b0; CLR = 1'b0; probe = 1'b0;
        #2 RST_n = 1'b0;
        #1;
        chk("rst_SMP_CNT", int'(SMP_CNT), 0);
        chk("rst_ERR_CNT", int'(ERR_CNT), 0);
        chk("rst_DONE", int'(DONE), 0);
        chk("rst_PASS", int'(PASS), 0);
        chk("rst_LD_FULL", int'(LD_FULL), 0);
        chk("rst_FIRST_ERR_GOT", int'(FIRST_ERR_GOT), 0);
        model_clear();
        @(negedge CLK);
        RST_n = 1'b1;
        ld(8'h7F, 1'b0);
        ld(8'h81, 1'b0);
        st();
        snd(8'h7F);
        snd(8'h81);
        idl(1'b1);

        idl(1'b0);
        @(negedge CLK);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/iir_out_checker.md
# iir_out_checker

Synthesizable receiver-side checker for the 8-bit IIR filter's output stream (DOUT/VOUT). It sits where the bench's data sink sits and consumes the filter's output handshake. It holds a golden sample table loaded over a simple write port and compares every valid output sample against it in order. It reports sample and error counts, first-failure information, timeout and overrun, and a PASS/DONE verdict that can drive END_SIM.

## Interface
- DEPTH, 256: golden table entries (power of two, ≥2); index width AW = log2(DEPTH)
- NB, 8: sample width, two's complement
- TIMEOUT, 1024: max idle cycles in RUN between valid samples before abort
- CLK  in  1  clock, all state updates on rising edge
- RST_n  in  1  asynchronous active-low reset
- LD_VALID  in  1  golden write strobe
- LD_DATA  in  NB  golden sample, written at the next free index
- START  in  1  begin checking (level, sampled per cycle)
- CLR  in  1  synchronous clear to IDLE, priority over all other inputs
- VIN  in  1  filter output valid (connects to VOUT)
- DIN  in  NB  filter output sample (connects to DOUT)
- LD_FULL  out  1  table holds DEPTH entries
- SMP_CNT  out  AW+1  samples checked
- ERR_CNT  out  AW+1  mismatching samples
- FIRST_ERR_IDX  out  AW  index of first mismatch
- FIRST_ERR_GOT  out  NB  DIN value at first mismatch
- DONE  out  1  check finished (sticky)
- PASS  out  1  valid only with DONE
- TIMED_OUT  out  1  RUN aborted by watchdog (sticky)
- OVERRUN  out  1  VIN seen in DONE (sticky)

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - LD_VALID writes mem[0], sets n_loaded=1, goes to LOAD.
  - START goes to RUN.
- LOAD:
  - LD_VALID writes mem[n_loaded] and increments n_loaded while n_loaded<DEPTH.
  - At n_loaded=DEPTH, LD_VALID is ignored and LD_FULL=1.
  - START goes to RUN. If LD_VALID and START are high in the same cycle, the write completes first, then the state goes to RUN.
- RUN, per edge with VIN=1:
  - golden = mem[SMP_CNT].
  - A mismatch increments ERR_CNT.
  - On the first mismatch, FIRST_ERR_IDX and FIRST_ERR_GOT are captured.
  - SMP_CNT increments on every valid sample.
  - LD_VALID is ignored in RUN.
- RUN exits:
  - When SMP_CNT reaches n_loaded, go to DONE.
  - If n_loaded=0 on entry, go to DONE on the next edge with PASS=0 (nothing checked).
  - If the watchdog counter reaches TIMEOUT with no VIN, go to DONE with TIMED_OUT=1 and PASS=0.
  - The watchdog counter is cleared by every VIN.
- DONE:
  - PASS = (ERR_CNT==0) && !TIMED_OUT && (n_loaded>0).
  - VIN sets OVERRUN; counters are frozen.
  - Only CLR or reset leaves DONE.
- Compare: mismatch when DIN != golden, as bitwise equality.
- Counters never wrap: SMP_CNT ≤ n_loaded ≤ DEPTH, and ERR_CNT ≤ SMP_CNT.
- Reset or CLR: every output is 0, FIRST_ERR_* are 0, n_loaded=0, and the state is IDLE. The memory contents are don't-care.
- Reset mid-RUN discards all progress, with no partial verdict.

## Timing
- Golden read is combinational from the register array, so there is no lookup latency. A sample at edge k updates SMP_CNT, ERR_CNT and FIRST_ERR_* visibly after edge k.
- DONE rises after the same edge that accepts the last golden sample, which means 0 cycles extra.
- Back-to-back VIN every cycle is supported at full rate, with no stall and no back-pressure signal.
- START is accepted at the first edge where it is sampled high in IDLE/LOAD.
- The timeout abort is seen at edge TIMEOUT after the last VIN, or after RUN entry if no VIN has arrived.
- All outputs are registered.

## Configuration
- IIR_CHK_TOL_EN:
  - Defined: a mismatch requires |DIN − golden| > 1 LSB. The difference is computed as a signed NB+1-bit value, with no overflow at −128 vs 127, so a fixed-point rounding skew of ±1 passes.
  - Undefined: exact equality, with no difference logic synthesized.

## Test plan
- Load 4 samples {5, −3, 127, −128}, START, drive VIN with matching DIN on consecutive cycles -> DONE after the 4th edge, SMP_CNT=4, ERR_CNT=0, PASS=1.
- Same load, DIN third sample = 126 -> ERR_CNT=1, FIRST_ERR_IDX=2, FIRST_ERR_GOT=126, PASS=0. With IIR_CHK_TOL_EN: ERR_CNT=0, PASS=1. With golden −128 and DIN 127, both builds flag an error.
- TIMEOUT=16, load 3 samples, send 1 VIN, then idle -> DONE 16 cycles later, TIMED_OUT=1, SMP_CNT=1, PASS=0.
- Load DEPTH+2 writes -> LD_FULL=1, n_loaded=DEPTH, extra writes ignored; START with no loads -> DONE next edge, PASS=0.
- After DONE, pulse VIN -> OVERRUN=1, counters unchanged; CLR -> all outputs 0, state IDLE.
- Assert RST_n low mid-RUN, asynchronously between edges -> outputs 0 immediately; after release, a fresh load/check passes normally.
